// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - MIPS fetch stage: PC, ROM addressing and IF/ID register
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH   = 32,
    parameter int                    MEMORY_DEPTH = 32,
    parameter logic [DATA_WIDTH-1:0] PC_RESET     = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD     = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [DATA_WIDTH-1:0] pc_o,
    input  logic [DATA_WIDTH-1:0] instruction_i,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_target_i,
    output logic [DATA_WIDTH-1:0] if_id_instruction_o,
    output logic [DATA_WIDTH-1:0] if_id_pc_plus4_o,
    output logic                  if_id_valid_o,
    output logic                  misaligned_o,
    output logic                  range_err_o,
    output logic [31:0]           fetch_count_o
);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] pc4_q, pc4_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic [31:0]           cnt_q, cnt_d;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] target_aligned;

    // Modulo-2^DATA_WIDTH increment; the top word wraps to address 0.
    assign pc_plus4       = pc_q + DATA_WIDTH'(4);
    assign target_aligned = {redirect_target_i[DATA_WIDTH-1:2], 2'b00};

    // Next-state selection with priority redirect > stall > advance.
    always_comb begin
        pc_d    = pc_q;
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (redirect_i) begin
            // The instruction fetched this cycle is on the wrong path: squash it.
            pc_d    = target_aligned;
            instr_d = NOP_WORD;
            valid_d = 1'b0;
            if (redirect_target_i[1:0] != 2'b00) begin
                mis_d = 1'b1;
            end
        end else if (!stall_i) begin
            pc_d    = pc_plus4;
            instr_d = instruction_i;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            cnt_d   = cnt_q + 32'd1;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= PC_RESET;
            instr_q <= NOP_WORD;
            pc4_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_o                = pc_q;
    assign if_id_instruction_o = instr_q;
    assign if_id_pc_plus4_o    = pc4_q;
    assign if_id_valid_o       = valid_q;
    assign misaligned_o        = mis_q;
    assign fetch_count_o       = cnt_q;

    // Status only: fetch is not blocked when the PC leaves the ROM.
    assign range_err_o = (pc_q >> 2) >= DATA_WIDTH'(MEMORY_DEPTH);

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the pipelined MIPS core. Sits directly upstream of the combinational program-memory ROM.
- Owns the program counter, drives the ROM byte address, and captures the returned instruction into the IF/ID pipeline register for the decode stage.
- Handles sequential PC+4 advance, hazard stalls, and branch/jump redirects with bubble insertion.

Parameters:
DATA_WIDTH, 32, width of PC, addresses and instruction words
MEMORY_DEPTH, 32, number of words in the program ROM; used for the range check
PC_RESET, 32'h0000_0000, PC value loaded on reset (byte address, word aligned)
NOP_WORD, 32'h0000_0000, instruction word inserted as a bubble (sll $0,$0,0)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
pc_o  output  DATA_WIDTH  current PC; drives the program-memory Address input
instruction_i  input  DATA_WIDTH  ROM output; a combinational function of pc_o, valid in the same cycle
stall_i  input  1  hazard unit request to hold PC and IF/ID
redirect_i  input  1  taken branch, j, jal or jr; load redirect_target_i
redirect_target_i  input  DATA_WIDTH  byte address of the redirect destination
if_id_instruction_o  output  DATA_WIDTH  registered instruction for decode
if_id_pc_plus4_o  output  DATA_WIDTH  registered PC+4 of that instruction
if_id_valid_o  output  1  IF/ID holds a real instruction (0 = bubble)
misaligned_o  output  1  sticky flag: a redirect target had bits [1:0] != 0
range_err_o  output  1  combinational: (pc_o >> 2) >= MEMORY_DEPTH
fetch_count_o  output  32  number of instructions loaded into IF/ID as valid

Behaviour:
- Reset (reset=0, asynchronous, effective mid-cycle):
  - pc_o=PC_RESET, if_id_instruction_o=NOP_WORD, if_id_pc_plus4_o=0, if_id_valid_o=0, misaligned_o=0, fetch_count_o=0.
  - range_err_o follows pc_o combinationally.
- Release is synchronous to the first rising edge with reset=1. The first valid IF/ID entry appears one clock after release.
- Per rising edge, priority is redirect > stall > advance:
  - Redirect (redirect_i=1, stall_i ignored):
    - PC <= {redirect_target_i[31:2],2'b00}.
    - IF/ID <= bubble: instruction=NOP_WORD, pc_plus4 unchanged, valid=0.
    - fetch_count_o unchanged.
    - If redirect_target_i[1:0] != 0, misaligned_o <= 1.
  - Stall (stall_i=1, redirect_i=0): PC, IF/ID contents, valid and fetch_count_o all hold.
  - Advance (both 0):
    - PC <= PC+4.
    - IF/ID <= {instruction_i, PC+4, valid=1}.
    - fetch_count_o <= fetch_count_o+1.
- Latency: the instruction at address A is presented on IF/ID in the cycle after pc_o=A, provided that cycle was an advance.
- Arithmetic and wrap-around:
  - PC+4 is modulo 2^DATA_WIDTH: 32'hFFFF_FFFC advances to 32'h0000_0000.
  - fetch_count_o wraps from 32'hFFFF_FFFF to 0.
- misaligned_o is sticky: only reset clears it.
- range_err_o is a status output only. Fetch continues, and the ROM value is captured as-is.
- A redirect whose target equals the current PC is legal: it still inserts one bubble.
- Back-to-back redirects insert one bubble per cycle; PC tracks each target.
- No combinational path from instruction_i to pc_o. All outputs except range_err_o are registered.

Test Plan:
- Reset then 4 advance cycles, ROM words 0x20080005, 0x20090003, 0x01095020, 0xAC0A0000 at 0,4,8,12 -> pc_o steps 0,4,8,12,16; IF/ID shows each word with pc_plus4 4,8,12,16, valid=1; fetch_count_o=4.
- At pc_o=8 hold stall_i=1 for 3 cycles -> pc_o stays 8; IF/ID holds 0x20090003 / pc_plus4=8; fetch_count_o frozen; resumes at pc_o=12 when released.
- At pc_o=12 assert redirect_i with target 0x40 and stall_i=1 in the same cycle -> next pc_o=0x40, if_id_valid_o=0, IF/ID instruction=0x00000000, fetch_count_o unchanged; next advance loads the word at 0x40.
- Redirect target 0x22 -> pc_o=0x20, misaligned_o=1 and stays 1 across further fetches until reset.
- Force the PC to 0xFFFFFFFC via redirect, then advance -> pc_o=0, IF/ID pc_plus4=0; with MEMORY_DEPTH=32, range_err_o=1 at 0xFFFFFFFC and 0 at 0.
- Pull reset low asynchronously between edges while pc_o=0x10 and valid=1 -> all outputs take their reset values immediately, without waiting for a clock edge.
